// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX stage ALU with EX/MEM pipeline register and optional iterative multiplier
//
// Purpose: selects operands, executes the ALU operation and registers the result
//          plus pass-through controls into EX/MEM. With EX_MUL_EN defined, op 8
//          runs a 16-cycle shift-add multiply and stalls the front end meanwhile.
// Macro:   EX_MUL_EN  - enables the multiplier FSM; otherwise op 8 yields 0.
// Ports:
//   clk_i, rst_n (sync, active-low), ex_flush_i (kill instruction in EX)
//   WB_i, MEM_i, EX_i, PC_i, RS_data_i, RT_data_i, SE_i, Zerofilled_i,
//   func_i, RT_reg_i, RD_reg_i                    - ID/EX inputs
//   stall_o                                        - combinational hold request
//   WB_o, MEM_o, ALU_result_o, store_data_o, branch_tgt_o, zero_o, dst_reg_o
//                                                  - registered EX/MEM outputs

module ex_mem_stage (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        ex_flush_i,
    input  logic [1:0]  WB_i,
    input  logic [1:0]  MEM_i,
    input  logic [6:0]  EX_i,
    input  logic [15:0] PC_i,
    input  logic [15:0] RS_data_i,
    input  logic [15:0] RT_data_i,
    input  logic [15:0] SE_i,
    input  logic [15:0] Zerofilled_i,
    input  logic [3:0]  func_i,
    input  logic [2:0]  RT_reg_i,
    input  logic [2:0]  RD_reg_i,
    output logic        stall_o,
    output logic [1:0]  WB_o,
    output logic [1:0]  MEM_o,
    output logic [15:0] ALU_result_o,
    output logic [15:0] store_data_o,
    output logic [15:0] branch_tgt_o,
    output logic        zero_o,
    output logic [2:0]  dst_reg_o
);

    logic        unused_ex6;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  op;
    logic [15:0] alu_res;
    logic [15:0] result;
    logic        bubble;

    logic [1:0]  wb_q, wb_d, mem_q, mem_d;
    logic [15:0] alu_q, alu_d, store_q, store_d, tgt_q, tgt_d;
    logic        zero_q, zero_d;
    logic [2:0]  dst_q, dst_d;

    assign unused_ex6 = EX_i[6];

    assign op_a = RS_data_i;
    assign op_b = EX_i[3] ? (EX_i[5] ? Zerofilled_i : SE_i) : RT_data_i;
    assign op   = (EX_i[2:0] == 3'b111) ? func_i : {1'b0, EX_i[2:0]};

    // Single-cycle ALU; op 8 is 0 here because the product comes from the FSM.
    always_comb begin
        alu_res = 16'h0000;
        case (op)
            4'd0: alu_res = op_a + op_b;
            4'd1: alu_res = op_a - op_b;
            4'd2: alu_res = op_a & op_b;
            4'd3: alu_res = op_a | op_b;
            4'd4: alu_res = op_a ^ op_b;
            4'd5: alu_res = {15'd0, $signed(op_a) < $signed(op_b)};
            4'd6: alu_res = op_a << op_b[3:0];
            4'd7: alu_res = op_a >> op_b[3:0];
            default: alu_res = 16'h0000;
        endcase
    end

`ifdef EX_MUL_EN
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic        use_prod;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            acc_q    <= 16'h0000;
            mcand_q  <= 16'h0000;
            mplier_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    // Multiplicand shifts left and multiplier right, so bit 0 of the
    // multiplier always selects the correctly weighted partial product.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (ex_flush_i) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op == 4'd8) begin
                        state_d  = S_BUSY;
                        cnt_d    = 4'd0;
                        acc_d    = 16'h0000;
                        mcand_d  = op_a;
                        mplier_d = op_b;
                    end
                end
                S_BUSY: begin
                    acc_d    = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_o  = 1'b0;
        bubble   = 1'b0;
        use_prod = 1'b0;
        if (!rst_n) begin
            stall_o = 1'b0;
        end else if (ex_flush_i) begin
            bubble = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op == 4'd8) begin
                        stall_o = 1'b1;
                        bubble  = 1'b1;
                    end
                end
                S_BUSY: begin
                    if (cnt_q != 4'd15) begin
                        stall_o = 1'b1;
                        bubble  = 1'b1;
                    end else begin
                        use_prod = 1'b1;
                    end
                end
                default: bubble = 1'b1;
            endcase
        end
    end

    // acc_d already includes the last partial product on the completing cycle.
    assign result = use_prod ? acc_d : alu_res;
`else
    assign stall_o = 1'b0;
    assign bubble  = ex_flush_i;
    assign result  = alu_res;
`endif

    always_comb begin
        wb_d    = WB_i;
        mem_d   = MEM_i;
        alu_d   = result;
        store_d = RT_data_i;
        tgt_d   = PC_i + SE_i;
        zero_d  = (result == 16'h0000);
        dst_d   = EX_i[4] ? RD_reg_i : RT_reg_i;
        if (bubble) begin
            wb_d    = 2'b00;
            mem_d   = 2'b00;
            alu_d   = 16'h0000;
            store_d = 16'h0000;
            tgt_d   = 16'h0000;
            zero_d  = 1'b0;
            dst_d   = 3'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            wb_q    <= 2'b00;
            mem_q   <= 2'b00;
            alu_q   <= 16'h0000;
            store_q <= 16'h0000;
            tgt_q   <= 16'h0000;
            zero_q  <= 1'b0;
            dst_q   <= 3'd0;
        end else begin
            wb_q    <= wb_d;
            mem_q   <= mem_d;
            alu_q   <= alu_d;
            store_q <= store_d;
            tgt_q   <= tgt_d;
            zero_q  <= zero_d;
            dst_q   <= dst_d;
        end
    end

    assign WB_o         = wb_q;
    assign MEM_o        = mem_q;
    assign ALU_result_o = alu_q;
    assign store_data_o = store_q;
    assign branch_tgt_o = tgt_q;
    assign zero_o       = zero_q;
    assign dst_reg_o    = dst_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - scoreboard bench for ex_mem_stage with a cycle-level reference model

module tb_ex_mem_stage;

`ifdef EX_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0]  wb;
        logic [1:0]  mem;
        logic [6:0]  ex;
        logic [15:0] pc;
        logic [15:0] rs;
        logic [15:0] rt;
        logic [15:0] se;
        logic [15:0] zf;
        logic [3:0]  func;
        logic [2:0]  rt_reg;
        logic [2:0]  rd_reg;
    } instr_t;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_flush_i = 1'b0;
    logic [1:0]  WB_i = '0, MEM_i = '0;
    logic [6:0]  EX_i = '0;
    logic [15:0] PC_i = '0, RS_data_i = '0, RT_data_i = '0, SE_i = '0, Zerofilled_i = '0;
    logic [3:0]  func_i = '0;
    logic [2:0]  RT_reg_i = '0, RD_reg_i = '0;
    logic        stall_o;
    logic [1:0]  WB_o, MEM_o;
    logic [15:0] ALU_result_o, store_data_o, branch_tgt_o;
    logic        zero_o;
    logic [2:0]  dst_reg_o;

    ex_mem_stage dut (
        .clk_i(clk_i), .rst_n(rst_n), .ex_flush_i(ex_flush_i),
        .WB_i(WB_i), .MEM_i(MEM_i), .EX_i(EX_i), .PC_i(PC_i),
        .RS_data_i(RS_data_i), .RT_data_i(RT_data_i), .SE_i(SE_i),
        .Zerofilled_i(Zerofilled_i), .func_i(func_i),
        .RT_reg_i(RT_reg_i), .RD_reg_i(RD_reg_i), .stall_o(stall_o),
        .WB_o(WB_o), .MEM_o(MEM_o), .ALU_result_o(ALU_result_o),
        .store_data_o(store_data_o), .branch_tgt_o(branch_tgt_o),
        .zero_o(zero_o), .dst_reg_o(dst_reg_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    logic [55:0] exp_q[$];

    // reference model state: an in-flight multiply is just a countdown and a product
    bit          busy = 1'b0;
    int          remaining = 0;
    logic [15:0] prod = '0;
    bit          last_stall = 1'b0;

    task automatic check(input string name, input logic [55:0] act, input logic [55:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h", name, act, exp);
    endtask

    function automatic logic [15:0] ref_alu(input int op, input logic [15:0] a, input logic [15:0] b);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            0: return 16'((a + b) % 65536);
            1: return 16'((32'(a) + 65536 - 32'(b)) % 65536);
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (sa < sb) ? 16'd1 : 16'd0;
            6: return 16'((32'(a) * (32'd1 << b[3:0])) % 65536);
            7: return 16'(32'(a) / (32'd1 << b[3:0]));
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [55:0] pack_out(input instr_t ins, input logic [15:0] res);
        logic [2:0] dst;
        dst = ins.ex[4] ? ins.rd_reg : ins.rt_reg;
        return {ins.wb, ins.mem, res, ins.rt, 16'(ins.pc + ins.se), (res == 16'd0), dst};
    endfunction

    function automatic instr_t mk(input logic [2:0] op3, input logic [3:0] fn,
                                  input logic [15:0] a, input logic [15:0] b);
        instr_t ins;
        ins.wb     = 2'($urandom_range(1, 3));
        ins.mem    = 2'($urandom);
        ins.ex     = {3'b000, 1'($urandom), 1'b0, op3};
        ins.pc     = 16'($urandom);
        ins.rs     = a;
        ins.rt     = b;
        ins.se     = 16'($urandom);
        ins.zf     = 16'($urandom);
        ins.func   = fn;
        ins.rt_reg = 3'($urandom);
        ins.rd_reg = 3'($urandom);
        return ins;
    endfunction

    function automatic instr_t rand_instr();
        instr_t ins;
        logic [15:0] a, b;
        a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 31)) : 16'($urandom);
        b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 31)) : 16'($urandom);
        ins = mk(3'($urandom), ($urandom_range(0, 2) == 0) ? 4'd8 : 4'($urandom), a, b);
        ins.ex = 7'($urandom);
        return ins;
    endfunction

    // One clock of stimulus: drive, check the combinational stall, predict EX/MEM.
    task automatic step(input instr_t ins, input bit fl, input bit rs_n);
        logic [15:0] a, b, res;
        int op;
        bit exp_stall;
        logic [55:0] exp;
        @(negedge clk_i);
        rst_n = rs_n; ex_flush_i = fl;
        WB_i = ins.wb; MEM_i = ins.mem; EX_i = ins.ex; PC_i = ins.pc;
        RS_data_i = ins.rs; RT_data_i = ins.rt; SE_i = ins.se; Zerofilled_i = ins.zf;
        func_i = ins.func; RT_reg_i = ins.rt_reg; RD_reg_i = ins.rd_reg;
        a  = ins.rs;
        b  = ins.ex[3] ? (ins.ex[5] ? ins.zf : ins.se) : ins.rt;
        op = (ins.ex[2:0] == 3'b111) ? int'(ins.func) : int'(ins.ex[2:0]);
        exp_stall = rs_n && !fl && (busy ? (remaining != 1) : (MUL_EN && op == 8));
        #1;
        check("stall_o", 56'(stall_o), 56'(exp_stall));
        exp = '0;
        if (!rs_n || fl) begin
            busy = 1'b0;
        end else if (busy) begin
            remaining--;
            if (remaining == 0) begin
                exp  = pack_out(ins, prod);
                busy = 1'b0;
            end
        end else if (MUL_EN && op == 8) begin
            busy      = 1'b1;
            remaining = 16;
            prod      = 16'((32'(a) * 32'(b)) % 65536);
        end else begin
            res = ref_alu(op, a, b);
            exp = pack_out(ins, res);
        end
        exp_q.push_back(exp);
        last_stall = exp_stall;
    endtask

    task automatic run_instr(input instr_t ins);
        step(ins, 1'b0, 1'b1);
        while (last_stall) step(ins, 1'b0, 1'b1);
    endtask

    // monitor: EX/MEM presents a new value after every edge
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                check("exmem", {WB_o, MEM_o, ALU_result_o, store_data_o, branch_tgt_o, zero_o, dst_reg_o},
                      exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        instr_t ins, mul;
        bit fl, rs;
        step(mk(3'd0, 4'd0, 16'h1111, 16'h2222), 1'b0, 1'b0);
        step(mk(3'd0, 4'd0, 16'h1111, 16'h2222), 1'b1, 1'b0);
        run_instr(mk(3'd0, 4'd0, 16'h0005, 16'h0003));
        run_instr(mk(3'd1, 4'd0, 16'h1234, 16'h1234));
        run_instr(mk(3'd5, 4'd0, 16'h8000, 16'h0001));
        run_instr(mk(3'd7, 4'd6, 16'h00F1, 16'h0004));
        run_instr(mk(3'd7, 4'd8, 16'h0007, 16'h0009));
        run_instr(mk(3'd7, 4'd8, 16'h0100, 16'h0100));
        run_instr(mk(3'd7, 4'd8, 16'hFFFF, 16'hFFFF));
        run_instr(mk(3'd0, 4'd0, 16'h0001, 16'h0001));
        // flush at cnt==5, then a clean multiply
        mul = mk(3'd7, 4'd8, 16'h1234, 16'h0057);
        step(mul, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) step(mul, 1'b0, 1'b1);
        step(mul, 1'b1, 1'b1);
        run_instr(mk(3'd7, 4'd8, 16'h0003, 16'h0005));
        // reset at cnt==10, then a single-cycle add
        mul = mk(3'd7, 4'd8, 16'h00AB, 16'h00CD);
        step(mul, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) step(mul, 1'b0, 1'b1);
        step(mul, 1'b0, 1'b0);
        run_instr(mk(3'd0, 4'd0, 16'h7000, 16'h1000));
        // flush on the issue cycle and on the completion cycle
        step(mk(3'd7, 4'd8, 16'h0002, 16'h0002), 1'b1, 1'b1);
        mul = mk(3'd7, 4'd8, 16'h0011, 16'h0022);
        step(mul, 1'b0, 1'b1);
        for (int k = 0; k < 15; k++) step(mul, 1'b0, 1'b1);
        step(mul, 1'b1, 1'b1);
        // randomized traffic; inputs hold while the model says the front end is stalled
        ins = rand_instr();
        for (int n = 0; n < 600; n++) begin
            if (!last_stall) ins = rand_instr();
            fl = ($urandom_range(0, 40) == 0);
            rs = ($urandom_range(0, 80) != 0);
            step(ins, fl, rs);
        end
        @(posedge clk_i);
        #2;
        check("drain", 56'(exp_q.size()), 56'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
